// File: rtl/adc_capture_ctrl.sv
// Write-side capture controller: resets the sample FIFO, fills it, waits for drain.
// Define TEST_PATTERN_EN to build the ramp test pattern selected by test_mode.
module adc_capture_ctrl #(
  parameter int DATA_W     = 16,
  parameter int RST_CYCLES = 8,
  parameter int DECIM_W    = 8
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               arm,
  input  logic               abort,
  input  logic               continuous,
  input  logic [DECIM_W-1:0] decim,
  input  logic               test_mode,
  input  logic [DATA_W-1:0]  adc_data,
  input  logic               adc_valid,
  input  logic               full,
  input  logic               empty,
  input  logic               wr_rst_busy,
  output logic               fifo_rst,
  output logic               wr_en,
  output logic [DATA_W-1:0]  din,
  output logic               busy,
  output logic [15:0]        capture_count
);

  localparam int RC_W =
    (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RC_W-1:0] RC_LOAD =
    RC_W'(RST_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RESET,
    S_WAIT,
    S_FILL,
    S_DRAIN
  } state_t;

  state_t              state;
  logic [RC_W-1:0]     rcnt;
  logic [DECIM_W-1:0]  dcnt;
  logic [DECIM_W-1:0]  decim_l;
  logic                cont_l;
  logic [DATA_W-1:0]   adc_data_q;
  logic                adc_valid_q;
  logic                fill_entry;

  assign busy  = (state != S_IDLE);
  assign wr_en = (state == S_FILL) & adc_valid_q
               & (dcnt == '0) & ~full & ~abort;
  assign fill_entry = (state == S_WAIT)
                    & ~wr_rst_busy & ~abort;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      adc_data_q  <= '0;
      adc_valid_q <= 1'b0;
    end else begin
      adc_data_q  <= adc_data;
      adc_valid_q <= adc_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state         <= S_IDLE;
      fifo_rst      <= 1'b0;
      rcnt          <= '0;
      dcnt          <= '0;
      decim_l       <= '0;
      cont_l        <= 1'b0;
      capture_count <= '0;
    end else if (abort) begin
      state    <= S_IDLE;
      fifo_rst <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (arm) begin
            state    <= S_RESET;
            fifo_rst <= 1'b1;
            rcnt     <= RC_LOAD;
            cont_l   <= continuous;
            decim_l  <= decim;
          end
        end
        S_RESET: begin
          if (rcnt == '0) begin
            state    <= S_WAIT;
            fifo_rst <= 1'b0;
          end else begin
            rcnt <= rcnt - RC_W'(1);
          end
        end
        S_WAIT: begin
          if (!wr_rst_busy) begin
            state <= S_FILL;
            dcnt  <= '0;
          end
        end
        S_FILL: begin
          // keeps counting on full so the phase stays tied to valid samples
          if (adc_valid_q) begin
            if (dcnt == decim_l) dcnt <= '0;
            else dcnt <= dcnt + DECIM_W'(1);
          end
          if (full) state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (empty) begin
            capture_count <= capture_count + 16'd1;
            if (cont_l) begin
              state    <= S_RESET;
              fifo_rst <= 1'b1;
              rcnt     <= RC_LOAD;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        default: begin
          state    <= S_IDLE;
          fifo_rst <= 1'b0;
        end
      endcase
    end
  end

`ifdef TEST_PATTERN_EN
  logic [DATA_W-1:0] ramp;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      ramp <= '0;
    end else if (fill_entry) begin
      ramp <= '0;
    end else if (wr_en) begin
      ramp <= ramp + DATA_W'(1);
    end
  end

  assign din = test_mode ? ramp : adc_data_q;
`else
  logic unused_tp;
  assign unused_tp = test_mode ^ fill_entry;
  assign din = adc_data_q;
`endif

endmodule
